// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// 8N1 serial receiver for the host-command input. The asynchronous RX line
// is brought into the clk domain through a two-flop synchronizer. A falling
// edge on the synchronized line starts a frame. The start bit is re-checked
// at its midpoint to reject glitches. Eight data bits are then sampled
// LSB-first, one bit period apart, and the stop bit is checked last. A good
// frame updates rx_data and raises rdy. A low stop bit raises frm_err and
// leaves the previous byte in place.
//
// Parameters
//   BAUD_DIV  clocks per bit period; must be even and >= 8
//   HALF_DIV  clocks from the start-edge detection to the start-bit midpoint
//
// Ports
//   clk      system clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   RX       asynchronous serial line, idle high
//   clr_rdy  single-cycle acknowledge from the consumer; clears rdy/ovr_err
//   rx_data  last correctly framed byte
//   rdy      byte available, held until clr_rdy
//   frm_err  last frame had a low stop bit; cleared by the next good frame
//   ovr_err  a byte completed while rdy was still high
//   busy     high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  // Reload values: a load of N-1 gives a sample event N cycles later.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECV,
    STOP
  } state_t;

  state_t           state;
  logic             rx_meta;   // first synchronizer stage, may go metastable
  logic             rx_s;      // synchronized RX
  logic             rx_prev;   // rx_s one cycle earlier, for edge detection
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             fall_edge;
  logic             sample;

  // -------------------------------------------------------------------------
  // Synchronizer and edge history. All three flops reset to the idle level,
  // so releasing reset with the line high can never look like a start edge.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the values from before the clock edge; blocking
  // assignments here would collapse the synchronizer into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A held-low line (break) produces one edge only. A new start needs the
  // line to return high first.
  assign fall_edge = rx_prev & ~rx_s;

  // Sample event: the down-counter has reached zero. The counter idles at
  // zero in IDLE, but IDLE ignores this term.
  assign sample = (baud_cnt == '0);

  // NOTE: busy is a plain continuous assignment of the registered state, so
  // it is fully specified for every state and no latch can be inferred.
  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Receive FSM, baud counter, data path and status flags.
  // -------------------------------------------------------------------------
  // NOTE: the shift register and bit counter are reset together with the
  // control state. An aborted frame therefore leaves no partial data behind,
  // and the block never depends on power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      // The acknowledge is applied first. A set from STOP further down in
      // the same cycle overrides it, so a byte that completes on the
      // acknowledge cycle is not lost.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        ovr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall_edge) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end

        START: begin
          if (sample) begin
            if (!rx_s) begin
              // Start bit still low at its midpoint: a real frame.
              baud_cnt <= BAUD_LOAD;
              bit_cnt  <= '0;
              state    <= RECV;
            end else begin
              // Line already back high: glitch, drop it without side effects.
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        RECV: begin
          if (sample) begin
            // Right shift with the new bit entering at the MSB. After eight
            // samples, the first (LSB) bit has reached bit 0.
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            baud_cnt  <= BAUD_LOAD;
            if (bit_cnt == 4'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        STOP: begin
          if (sample) begin
            // The stop sample lands mid-stop-bit. Returning to IDLE now
            // leaves half a bit to catch a back-to-back start edge.
            state <= IDLE;
            if (rx_s) begin
              rx_data <= shift_reg;
              rdy     <= 1'b1;
              frm_err <= 1'b0;
              if (rdy) begin
                ovr_err <= 1'b1;
              end
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Directed bench for uart_rx_frame with a short bit period, so many frames
// fit in a small cycle budget. A table of frames, each with its expected
// status, is applied in a loop. Hand-written sequences cover exact rdy
// timing, glitch rejection, break hold-off, back-to-back overrun, the
// acknowledge/set collision and a reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int BAUD = 20;
  localparam int HALF = BAUD / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       busy;

  int tests;
  int fails;

  uart_rx_frame #(
    .BAUD_DIV(BAUD),
    .HALF_DIV(HALF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr_err(ovr_err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit: the run must end by itself even if the DUT misbehaves.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clock edges; return 1 time unit after the last edge, which is
  // where stimulus is driven and outputs are sampled.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame on rx, with each bit held for BAUD clocks. The stop level
  // is left on the line when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BAUD);
    end
    rx = stop_lvl;
    tick(BAUD);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    logic       clr_after;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_frm;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  int rdy_at;
  int busy_on;
  int busy_at_rdy;
  int busy_cnt;

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    rx      = 1'b1;
    clr_rdy = 1'b0;

    // Frame table. The state carries over from one entry to the next: the
    // table starts with rdy=0 and rx_data=0xA5.
    //               data   stop  clr   exp_data rdy   frm   ovr
    vecs[0] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

    // ---- Reset state ----
    tick(3);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rdy",     rdy,     1'b0);
    check("reset frm_err", frm_err, 1'b0);
    check("reset ovr_err", ovr_err, 1'b0);
    check("reset busy",    busy,    1'b0);
    rst_n = 1'b1;
    tick(3);

    // ---- Exact timing of one good frame (0xA5) ----
    // The line falls at tick 0. rx_s sees it 2 edges later (cycle 0), the FSM
    // enters START on the next edge, and rdy appears HALF+9*BAUD+1 cycles
    // after cycle 0.
    rdy_at      = -1;
    busy_on     = -1;
    busy_at_rdy = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int n = 1; n <= 12 * BAUD; n++) begin
          tick(1);
          if (busy && busy_on < 0) busy_on = n;
          if (rdy && rdy_at < 0) begin
            rdy_at      = n;
            busy_at_rdy = int'(busy);
          end
        end
      end
    join
    check("t1 busy rise cycle", busy_on, 3);
    check("t1 rdy rise cycle",  rdy_at,  3 + HALF + 9 * BAUD);
    check("t1 busy at rdy",     busy_at_rdy, 0);
    check("t1 rx_data",         rx_data, 8'hA5);
    check("t1 frm_err",         frm_err, 1'b0);
    check("t1 ovr_err",         ovr_err, 1'b0);
    pulse_clr();
    check("t1 rdy after clr",   rdy, 1'b0);

    // ---- Table-driven frames ----
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_lvl);
      rx = 1'b1;
      tick(4);
      check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d rdy", v),     rdy,     vecs[v].exp_rdy);
      check($sformatf("vec%0d frm_err", v), frm_err, vecs[v].exp_frm);
      check($sformatf("vec%0d ovr_err", v), ovr_err, vecs[v].exp_ovr);
      check($sformatf("vec%0d busy", v),    busy,    1'b0);
      if (vecs[v].clr_after) begin
        pulse_clr();
        check($sformatf("vec%0d rdy after clr", v), rdy,     1'b0);
        check($sformatf("vec%0d ovr after clr", v), ovr_err, 1'b0);
        check($sformatf("vec%0d frm after clr", v), frm_err, vecs[v].exp_frm);
      end
    end

    // ---- Glitch: line low for 3 clocks only ----
    // busy must be high for exactly the HALF cycles before the start-bit
    // midpoint check rejects the glitch.
    busy_cnt = 0;
    rx = 1'b0;
    for (int n = 1; n <= 3 * BAUD; n++) begin
      tick(1);
      if (n == 3) rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch busy cycles", busy_cnt, HALF);
    check("glitch rx_data",     rx_data,  8'hC3);
    check("glitch rdy",         rdy,      1'b0);
    check("glitch frm_err",     frm_err,  1'b0);
    check("glitch ovr_err",     ovr_err,  1'b0);

    // ---- Back-to-back 0x11, 0x22 with no acknowledge ----
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    check("b2b rx_data", rx_data, 8'h22);
    check("b2b rdy",     rdy,     1'b1);
    check("b2b ovr_err", ovr_err, 1'b1);
    check("b2b frm_err", frm_err, 1'b0);
    pulse_clr();
    check("b2b rdy after clr", rdy,     1'b0);
    check("b2b ovr after clr", ovr_err, 1'b0);
    check("b2b data kept",     rx_data, 8'h22);

    // ---- Framing error, then break held low ----
    send_frame(8'h11, 1'b1);
    tick(2);
    pulse_clr();
    send_frame(8'h3C, 1'b0);   // rx stays low after this frame
    busy_cnt = 0;
    for (int n = 0; n < 3 * BAUD; n++) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    check("break no retrigger", busy_cnt, 0);
    check("frm rx_data kept",   rx_data,  8'h11);
    check("frm rdy",            rdy,      1'b0);
    check("frm frm_err",        frm_err,  1'b1);
    rx = 1'b1;
    tick(5);
    send_frame(8'h42, 1'b1);
    tick(4);
    check("after break rx_data", rx_data, 8'h42);
    check("after break rdy",     rdy,     1'b1);
    check("after break frm_err", frm_err, 1'b0);
    pulse_clr();

    // ---- Acknowledge on the exact cycle rdy sets ----
    fork
      send_frame(8'h7E, 1'b1);
      begin
        tick(2 + HALF + 9 * BAUD);
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
      end
    join
    tick(2);
    check("collide rdy",     rdy,     1'b1);
    check("collide rx_data", rx_data, 8'h7E);
    check("collide ovr_err", ovr_err, 1'b0);

    // ---- Asynchronous reset in the middle of data bit 4 of 0xFF ----
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(2 + 5 * BAUD + HALF);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst rx_data", rx_data, 8'h00);
        check("midrst rdy",     rdy,     1'b0);
        check("midrst frm_err", frm_err, 1'b0);
        check("midrst ovr_err", ovr_err, 1'b0);
        check("midrst busy",    busy,    1'b0);
        tick(1);
        rst_n = 1'b1;
      end
    join
    tick(4);
    check("post rst idle busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    tick(4);
    check("post rst rx_data", rx_data, 8'h5A);
    check("post rst rdy",     rdy,     1'b1);
    check("post rst frm_err", frm_err, 1'b0);
    check("post rst ovr_err", ovr_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
